// File: rtl/pipe_pkg.sv
// Shared IF/ID definitions: bubble instruction and the fetch-queue entry layout.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

  localparam fetch_entry_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pcplus4: '0};

endpackage

// File: rtl/fetch_queue_stage_if.sv
// IF/ID boundary signals: F-stage word in, D-stage register out, stall/flush control.
interface fetch_queue_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] InstrF_i;
  logic [DATA_WIDTH-1:0] PCF_i;
  logic [DATA_WIDTH-1:0] PCPlus4F_i;
  logic                  FetchValidF_i;
  logic                  FetchReadyF_o;
  logic                  StallD_i;
  logic                  FlushD_i;
  logic [DATA_WIDTH-1:0] InstrD_o;
  logic [DATA_WIDTH-1:0] PCD_o;
  logic [DATA_WIDTH-1:0] PCPlus4D_o;
  logic                  ValidD_o;
  logic [CNT_W-1:0]      Count_o;

  modport master (
    output InstrF_i, PCF_i, PCPlus4F_i, FetchValidF_i, StallD_i, FlushD_i,
    input  FetchReadyF_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, Count_o
  );

  modport slave (
    input  InstrF_i, PCF_i, PCPlus4F_i, FetchValidF_i, StallD_i, FlushD_i,
    output FetchReadyF_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, Count_o
  );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// DEPTH-entry FIFO of fetch entries; pointers wrap at DEPTH-1 so DEPTH need not be a power of two.
module fetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = pipe_pkg::fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       din,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// IF/ID stage: instruction queue in front of the D-stage register, with empty-queue bypass and flush.
module fetch_queue_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = XLEN,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
  input logic                clk,
  input logic                rst_n,
  fetch_queue_stage_if.slave fq
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
  } entry_t;

  localparam entry_t BUBBLE_D = '{instr: NOP_INSTR, pc: '0, pcplus4: '0};

  entry_t           in_entry;
  entry_t           head;
  entry_t           d_q;
  entry_t           d_d;
  logic             valid_q;
  logic             valid_d;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_push;

  assign in_entry = '{instr: fq.InstrF_i, pc: fq.PCF_i, pcplus4: fq.PCPlus4F_i};

  // Ready comes only from the registered count, never from stall/flush.
  assign fq.FetchReadyF_o = (count < CNT_W'(DEPTH));
  assign push             = fq.FetchValidF_i && fq.FetchReadyF_o;

  always_comb begin
    d_d       = d_q;
    valid_d   = valid_q;
    pop       = 1'b0;
    fifo_push = 1'b0;
    if (fq.FlushD_i) begin
      d_d     = BUBBLE_D;
      valid_d = 1'b0;
    end else begin
      fifo_push = push;
      if (!fq.StallD_i) begin
        if (count != '0) begin
          d_d     = head;
          valid_d = 1'b1;
          pop     = 1'b1;
        end else if (push) begin
          // Empty queue: word goes straight to D and is never stored.
          d_d       = in_entry;
          valid_d   = 1'b1;
          fifo_push = 1'b0;
        end else begin
          d_d     = BUBBLE_D;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= BUBBLE_D;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fq.FlushD_i),
    .push  (fifo_push),
    .pop   (pop),
    .din   (in_entry),
    .head  (head),
    .count (count)
  );

  assign fq.InstrD_o   = d_q.instr;
  assign fq.PCD_o      = d_q.pc;
  assign fq.PCPlus4D_o = d_q.pcplus4;
  assign fq.ValidD_o   = valid_q;
  assign fq.Count_o    = count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed + random bench for fetch_queue_stage with a FIFO scoreboard of accepted fetch words.
module tb_fetch_queue_stage;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [95:0] BUB   = {32'h00000013, 64'h0};

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  logic [95:0] sb [$];
  logic [95:0] ed;
  logic        ev;

  always #5 clk = ~clk;

  fetch_queue_stage_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fq ();

  fetch_queue_stage #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic s, input logic f,
                     input logic [31:0] instr, input logic [31:0] pc);
    fq.FetchValidF_i = v;
    fq.StallD_i      = s;
    fq.FlushD_i      = f;
    fq.InstrF_i      = instr;
    fq.PCF_i         = pc;
    fq.PCPlus4F_i    = pc + 32'd4;
  endtask

  task automatic check_all(input string where);
    chk({where, ".instrD"}, fq.InstrD_o, ed[95:64]);
    chk({where, ".pcD"},    fq.PCD_o, ed[63:32]);
    chk({where, ".pc4D"},   fq.PCPlus4D_o, ed[31:0]);
    chk({where, ".validD"}, 32'(fq.ValidD_o), 32'(ev));
    chk({where, ".count"},  32'(fq.Count_o), 32'(sb.size()));
    chk({where, ".ready"},  32'(fq.FetchReadyF_o), 32'(sb.size() < DEPTH));
  endtask

  // Update the reference with the inputs as driven, then clock and compare.
  task automatic tick(input string where);
    if (!rst_n || fq.FlushD_i) begin
      sb.delete();
      ed = BUB;
      ev = 1'b0;
    end else begin
      if (fq.FetchValidF_i && sb.size() < DEPTH)
        sb.push_back({fq.InstrF_i, fq.PCF_i, fq.PCPlus4F_i});
      if (!fq.StallD_i) begin
        if (sb.size() > 0) begin
          ed = sb.pop_front();
          ev = 1'b1;
        end else begin
          ed = BUB;
          ev = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ed = BUB;
    ev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Empty queue bypass, then bubble.
    drv(1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
    tick("bypass");
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("bubble");

    // Fill under stall; the fifth word must be dropped.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h10000000 + 32'(i), 32'h10 + 32'(4 * i));
      tick("fill");
    end
    chk("full.count", 32'(fq.Count_o), 32'd4);
    chk("full.ready", 32'(fq.FetchReadyF_o), 32'd0);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick("drain");

    // Push and pop together at count 2.
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h20000000 + 32'(i), 32'h40 + 32'(4 * i));
      tick("pre2");
    end
    for (int i = 2; i < 6; i++) begin
      drv(1'b1, 1'b0, 1'b0, 32'h20000000 + 32'(i), 32'h40 + 32'(4 * i));
      tick("pushpop");
    end
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick("drain2");

    // Flush with stall and a valid word in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h30000000 + 32'(i), 32'h80 + 32'(4 * i));
      tick("pre3");
    end
    drv(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hC0);
    tick("flush");
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) tick("postflush");

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h40000000 + 32'(i), 32'h100 + 32'(4 * i));
      tick("pre4");
    end
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("drain4");
    drv(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    ed = BUB;
    ev = 1'b0;
    check_all("asyncrst");
    tick("inrst");
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 32'h00A00113, 32'h200);
    tick("rstbypass");
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("rstbubble");

    for (int i = 0; i < 80; i++) begin
      drv(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
          $urandom, 32'h1000 + 32'(4 * i));
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised IF/ID boundary for the pipelined core. It replaces the plain fetch register with a DEPTH-entry instruction queue plus the D-stage output register. Decode can stall without back-pressuring fetch until the queue fills, and branch/jump redirects flush the queue and D stage in one cycle. It sits between instr_mem (F stage) and control_unit/sign_extend (D stage).

Parameters:
DATA_WIDTH, 32, width of instruction, PC and PC+4
DEPTH, 4, queue entries (>=2); pointers wrap DEPTH-1 -> 0, not a power-of-two mask
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
InstrF_i  in  DATA_WIDTH  fetched instruction
PCF_i  in  DATA_WIDTH  PC of InstrF_i
PCPlus4F_i  in  DATA_WIDTH  PCF_i+4
FetchValidF_i  in  1  F-stage word valid this cycle
FetchReadyF_o  out  1  queue can accept a word; equals (count < DEPTH)
StallD_i  in  1  decode holds its register
FlushD_i  in  1  redirect; kill queue and D stage
InstrD_o  out  DATA_WIDTH  D-stage instruction
PCD_o  out  DATA_WIDTH  D-stage PC
PCPlus4D_o  out  DATA_WIDTH  D-stage PC+4
ValidD_o  out  1  D-stage holds a real instruction
Count_o  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async assert, sync-safe deassert): count=0, rd/wr ptr=0, InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0. FetchReadyF_o=1 after reset.
- Priority per posedge: reset > flush > normal.
- push = FetchValidF_i && FetchReadyF_o; advance = !StallD_i.
- FetchReadyF_o depends only on registered count. It has no combinational path from StallD_i or FlushD_i.
- Flush: count/ptrs <= 0; D <= bubble (NOP_INSTR, 0, 0, ValidD=0); incoming word that cycle discarded. FlushD_i overrides StallD_i.
- Normal, advance=1:
  - count>0: D <= queue head, ValidD=1, pop. If push, also write tail.
  - count==0 and push: bypass; D <= {InstrF_i, PCF_i, PCPlus4F_i}, ValidD=1. Nothing written to queue.
  - count==0 and no push: D <= bubble, ValidD=0.
- Normal, advance=0: D holds all fields including ValidD; push writes tail; no pop.
- count' = count + (push && !bypass) - pop. Never exceeds DEPTH; never underflows.
- Full (count==DEPTH): FetchReadyF_o=0; FetchValidF_i ignored. The F stage must hold its PC; that is the F-stage's responsibility.
- Simultaneous push+pop at 0<count<DEPTH: count unchanged; the entry order is strict FIFO.
- Latency: F->D is 1 cycle when queue empty and not stalled; otherwise 1+count cycles.
- Reset mid-operation: all state cleared immediately on rst_n low; queued words lost.
- Queue storage contents need no reset; only pointers/count/D register are reset.

Decomposition:
- pipe_pkg: NOP_INSTR constant, fetch_entry_t struct {instr, pc, pcplus4} parameterised by DATA_WIDTH via localparam, and the bubble value constant.
- One sub-module fetch_fifo: DEPTH x fetch_entry_t storage with wr/rd pointers, count, push/pop/clear. Top handles bypass, D register and flush priority.

Test Plan:
- Reset -> ValidD_o=0, InstrD_o=0x00000013, Count_o=0, FetchReadyF_o=1.
- Empty, no stall, push {0x00500093, PC 0x0, 0x4} -> next cycle InstrD_o=0x00500093, PCD_o=0, ValidD_o=1, Count_o=0 (bypass).
- Hold StallD_i=1, push 4 words PC 0x10..0x1C -> Count_o=4, FetchReadyF_o=0, 5th word ignored. Release stall -> D shows PC 0x10,0x14,0x18,0x1C on consecutive cycles, then bubble.
- Count_o=2, push and advance same cycle -> Count_o stays 2; D order preserved.
- Count_o=3, StallD_i=1, assert FlushD_i with FetchValidF_i=1 -> next cycle Count_o=0, ValidD_o=0, InstrD_o=NOP; flushed word never appears.
- rst_n low mid-drain (Count_o=2) -> immediately, without waiting for clk, ValidD_o=0 and Count_o=0. After release, the first push bypasses with 1-cycle latency.
